// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-pass shift sequencer: FSM states, shift modes
// and the largest amount one combinational pass can apply.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_ROL = 1'b0;
  localparam logic MODE_SLL = 1'b1;

  localparam int STEP_MAX = 7;

endpackage

// File: rtl/shift_step.sv
// One combinational pass: rotate-left or zero-fill shift-left by k (0..2**K_W-1),
// built as a log-depth mux chain of 1/2/4-bit stages.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K_W    = 3
) (
  input  logic [K_W-1:0]    k,
  input  logic              mode,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  logic [K_W:0][DATA_W-1:0] w_stage;

  assign w_stage[0] = i_data;

  for (genvar s = 0; s < K_W; s++) begin : g_stage
    localparam int SH = 2 ** s;
    logic [DATA_W-1:0] w_rot;
    logic [DATA_W-1:0] w_sll;

    assign w_rot = {w_stage[s][DATA_W-1-SH:0], w_stage[s][DATA_W-1 -: SH]};
    assign w_sll = {w_stage[s][DATA_W-1-SH:0], {SH{1'b0}}};
    assign w_stage[s+1] = k[s] ? ((mode == MODE_SLL) ? w_sll : w_rot) : w_stage[s];
  end

  assign o_data = w_stage[K_W];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass shift engine: accepts one command, applies the total amount in
// passes of at most STEP_MAX, then holds the result on a valid/ready output.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K_W    = 3,
  parameter int AMT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amount,
  input  logic              i_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  state_t             r_state;
  state_t             w_next;
  logic [DATA_W-1:0]  r_data;
  logic [AMT_W-1:0]   r_rem;
  logic               r_mode;

  logic [K_W-1:0]     w_step;
  logic               w_last_pass;
  logic               w_accept;
  logic [DATA_W-1:0]  w_shifted;

  // Clamp the remaining amount to what a single pass can do.
  assign w_last_pass = (r_rem <= AMT_W'(STEP_MAX));
  assign w_step      = w_last_pass ? r_rem[K_W-1:0] : K_W'(STEP_MAX);
  assign w_accept    = i_valid && (r_state == S_IDLE);

  shift_step #(
    .DATA_W (DATA_W),
    .K_W    (K_W)
  ) u_step (
    .k      (w_step),
    .mode   (r_mode),
    .i_data (r_data),
    .o_data (w_shifted)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: the datapath registers are reset too, because o_data is defined
  // as 0 after reset and reads r_data directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_rem  <= '0;
      r_mode <= MODE_ROL;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_data <= i_data;
          r_rem  <= i_amount;
          r_mode <= i_mode;
        end
        S_RUN: begin
          r_data <= w_shifted;
          r_rem  <= r_rem - AMT_W'(w_step);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (i_amount == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last_pass) w_next = S_DONE;
      S_DONE:  if (i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == S_IDLE);
    o_valid = (r_state == S_DONE);
    o_busy  = (r_state != S_IDLE);
    o_data  = r_data;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, backpressure
// and reset corner sequences, then random commands against a behavioural model.
module tb_shift_sequencer;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 6;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [AMT_W-1:0]  i_amount;
  logic              i_mode;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  shift_sequencer dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_amount (i_amount),
    .i_mode   (i_mode),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_busy   (o_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [5:0] amount;
    logic       mode;
    logic [7:0] exp_data;
    int         exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Specification-level result: rotate by amount mod 8, or zero-fill shift
  // that empties the byte once the amount reaches 8.
  function automatic logic [7:0] model_data(input logic [7:0] d, input int amt, input logic m);
    logic [15:0] dd;
    if (m) return (amt >= 8) ? 8'h00 : 8'(d << amt);
    dd = {d, d} << (amt % 8);
    return dd[15:8];
  endfunction

  // Cycle (counting the accept edge as cycle 0) in which o_valid rises.
  function automatic int model_cyc(input int amt);
    return (amt + 6) / 7 + 1;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one command, measure its latency, and optionally stall the output.
  task automatic run_cmd(input string name, input logic [7:0] d, input logic [5:0] a,
                         input logic m, input logic [7:0] exp_d, input int exp_c,
                         input int stall);
    int n;
    check({name, " ready_before"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_data = d; i_amount = a; i_mode = m;
    i_ready = (stall == 0);
    tick();
    i_valid = 1'b0; i_data = 8'h00; i_amount = '0;
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, " cycle"}, 32'(n + 1), 32'(exp_c));
    check({name, " data"}, 32'(o_data), 32'(exp_d));
    for (int i = 0; i < stall; i++) tick();
    if (stall > 0) check({name, " held"}, {o_valid, o_data}, {1'b1, exp_d});
    i_ready = 1'b1;
    tick();
    check({name, " idle_after"}, {o_ready, o_valid, o_busy}, 3'b100);
  endtask

  vec_t vecs[$];

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_amount = '0; i_mode = 1'b0; i_ready = 1'b1;

    vecs.push_back('{8'hB1,  0, 1'b0, 8'hB1,  1});
    vecs.push_back('{8'h81,  3, 1'b0, 8'h0C,  2});
    vecs.push_back('{8'h81, 20, 1'b0, 8'h18,  4});
    vecs.push_back('{8'hFF,  5, 1'b1, 8'hE0,  2});
    vecs.push_back('{8'hFF,  9, 1'b1, 8'h00,  3});
    vecs.push_back('{8'h5A,  8, 1'b0, 8'h5A,  3});
    vecs.push_back('{8'h01,  7, 1'b0, 8'h80,  2});
    vecs.push_back('{8'h01,  8, 1'b0, 8'h01,  3});
    vecs.push_back('{8'hC3, 63, 1'b0, 8'hE1, 10});
    vecs.push_back('{8'hC3, 63, 1'b1, 8'h00, 10});
    vecs.push_back('{8'h01,  7, 1'b1, 8'h80,  2});
    vecs.push_back('{8'hA5,  1, 1'b1, 8'h4A,  2});

    tick();
    tick();
    i_rst = 1'b0;
    tick();
    check("reset outputs", {o_valid, o_data, o_ready, o_busy}, {1'b0, 8'h00, 1'b1, 1'b0});

    foreach (vecs[i])
      run_cmd($sformatf("vec%0d", i), vecs[i].data, vecs[i].amount, vecs[i].mode,
              vecs[i].exp_data, vecs[i].exp_cyc, 0);

    // Backpressure: result must hold and pulsed commands must be ignored.
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h81; i_amount = 6'd3; i_mode = 1'b0;
    tick();
    i_valid = 1'b0;
    tick();
    check("bp valid", {o_valid, o_data}, {1'b1, 8'h0C});
    for (int i = 0; i < 5; i++) begin
      i_valid = (i % 2 == 0); i_data = 8'hFF; i_amount = 6'd0;
      tick();
      check($sformatf("bp stall%0d", i), {o_valid, o_ready, o_data}, {1'b1, 1'b0, 8'h0C});
    end
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    check("bp release", {o_ready, o_valid, o_busy}, 3'b100);
    tick();
    check("bp not accepted", {o_busy, o_data}, {1'b0, 8'h0C});

    // Reset in the middle of a 9-pass command.
    i_valid = 1'b1; i_data = 8'h81; i_amount = 6'd63; i_mode = 1'b0;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    check("mid busy", {o_busy, o_valid}, 2'b10);
    i_rst = 1'b1;
    i_valid = 1'b1; i_data = 8'h77; i_amount = 6'd0;
    tick();
    check("mid reset", {o_valid, o_data, o_ready, o_busy}, {1'b0, 8'h00, 1'b1, 1'b0});
    tick();
    check("reset beats valid", {o_busy, o_data}, {1'b0, 8'h00});
    i_rst = 1'b0; i_valid = 1'b0;
    tick();
    run_cmd("post reset", 8'h01, 6'd1, 1'b0, 8'h02, 2, 0);

    // Random commands with random output stalls.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] d;
      int a;
      logic m;
      d = 8'($urandom);
      a = $urandom_range(0, 63);
      m = 1'($urandom);
      run_cmd($sformatf("rnd%0d", i), d, 6'(a), m, model_data(d, a, m), model_cyc(a),
              $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
